// File: rtl/seq_decoder38.sv
// -----------------------------------------------------------------------------
// seq_decoder38
//   Registered, handshaked 3-to-8 decoder with timed output strobes.
//   An accepted 3-bit code drives the matching one-hot line for HOLD_CYCLES
//   clocks. All lines are then blanked for GAP_CYCLES clocks, and after that
//   the block returns to IDLE and is ready for the next code.
//
// Parameters
//   HOLD_CYCLES : clocks each one-hot strobe is held (1 .. 2**CNT_W-1)
//   GAP_CYCLES  : blank clocks after each strobe (0 .. 2**CNT_W-1)
//   CNT_W       : width of the shared HOLD/GAP down-counter
//   ACTIVE_LOW  : 1 inverts oData (selected line low, idle all-ones)
//
// Ports
//   iClk    : clock, rising edge
//   iRst_n  : asynchronous active-low reset
//   iValid  : iCode is valid this cycle
//   iCode   : binary code Y2..Y0 to decode
//   iPause  : freezes the HOLD/GAP counter and state
//   iClear  : synchronous abort back to IDLE (no done pulse)
//   oReady  : block accepts a code this cycle (IDLE only)
//   oData   : decoded lines D7..D0
//   oBusy   : state is HOLD or GAP
//   oDone   : one-cycle pulse when a strobe+gap sequence completes
// -----------------------------------------------------------------------------
module seq_decoder38 #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iValid,
    input  logic [2:0] iCode,
    input  logic       iPause,
    input  logic       iClear,
    output logic       oReady,
    output logic [7:0] oData,
    output logic       oBusy,
    output logic       oDone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } stateType;

    localparam logic [7:0]       IDLE_DATA = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    // Only loaded when GAP_CYCLES > 0, so the wrap for GAP_CYCLES = 0 is unused.
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    stateType         stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [7:0]       dataReg, dataNext;
    logic             readyReg, busyReg, doneReg, doneNext;
    logic [7:0]       oneHot;

    // One comparator per output line; exactly one is true for any code.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : genDecode
            assign oneHot[gi] = (iCode == 3'(gi));
        end
    endgenerate

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        dataNext  = dataReg;
        doneNext  = 1'b0;

        if (iClear) begin
            // Abort beats everything, including a same-cycle accept.
            stateNext = IDLE;
            cntNext   = '0;
            dataNext  = IDLE_DATA;
        end else begin
            case (stateReg)
                IDLE: begin
                    // oReady is high exactly in IDLE, so iValid alone is the accept.
                    if (iValid) begin
                        stateNext = HOLD;
                        cntNext   = HOLD_LOAD;
                        dataNext  = oneHot ^ IDLE_DATA;
                    end
                end
                HOLD: begin
                    if (!iPause) begin
                        if (cntReg != '0) begin
                            cntNext = cntReg - CNT_W'(1);
                        end else begin
                            dataNext = IDLE_DATA;
                            if (GAP_CYCLES == 0) begin
                                stateNext = IDLE;
                                doneNext  = 1'b1;
                            end else begin
                                stateNext = GAP;
                                cntNext   = GAP_LOAD;
                            end
                        end
                    end
                end
                GAP: begin
                    if (!iPause) begin
                        if (cntReg != '0) begin
                            cntNext = cntReg - CNT_W'(1);
                        end else begin
                            stateNext = IDLE;
                            doneNext  = 1'b1;
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                    dataNext  = IDLE_DATA;
                end
            endcase
        end
    end

    // Ready/busy are registered from the next state so every output is a flop.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            dataReg  <= IDLE_DATA;
            readyReg <= 1'b1;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            dataReg  <= dataNext;
            readyReg <= (stateNext == IDLE);
            busyReg  <= (stateNext != IDLE);
            doneReg  <= doneNext;
        end
    end

    assign oReady = readyReg;
    assign oData  = dataReg;
    assign oBusy  = busyReg;
    assign oDone  = doneReg;

endmodule

// File: tb/tb_seq_decoder38.sv
// -----------------------------------------------------------------------------
// tb_seq_decoder38
//   Self-checking bench for seq_decoder38. dutA uses the default parameters,
//   dutB is an active-low, HOLD=1, GAP=0 build. Expected strobe values are
//   queued when a code is driven and compared when the DUT presents it.
// -----------------------------------------------------------------------------
module tb_seq_decoder38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dutA signals
    logic       rstN, valid, pause, clear;
    logic [2:0] code;
    logic       ready, busy, done;
    logic [7:0] data;

    // dutB signals
    logic       bRstN, bValid, bPause, bClear;
    logic [2:0] bCode;
    logic       bReady, bBusy, bDone;
    logic [7:0] bData;

    seq_decoder38 dutA (
        .iClk(clk), .iRst_n(rstN), .iValid(valid), .iCode(code),
        .iPause(pause), .iClear(clear),
        .oReady(ready), .oData(data), .oBusy(busy), .oDone(done)
    );

    seq_decoder38 #(
        .HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8), .ACTIVE_LOW(1)
    ) dutB (
        .iClk(clk), .iRst_n(bRstN), .iValid(bValid), .iCode(bCode),
        .iPause(bPause), .iClear(bClear),
        .oReady(bReady), .oData(bData), .oBusy(bBusy), .oDone(bDone)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] expQ[$];

    typedef struct {
        logic [2:0] code;
        logic [7:0] expData;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic popCheck(input string name);
        logic [7:0] e;
        if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %02h", name, data);
        end else begin
            e = expQ.pop_front();
            check(name, data, e);
            $display("[TB] strobe %s: oData=%02h expected=%02h", name, data, e);
        end
    endtask

    task automatic waitReady(input int limit);
        int n = 0;
        while (ready !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("readyWait", ready, 1);
    endtask

    // Drive a code on dutA, wait for acceptance, then compare the strobe.
    task automatic acceptA(input logic [2:0] c);
        valid = 1'b1;
        code  = c;
        expQ.push_back(8'd1 << c);
        waitReady(20);
        tick();
        valid = 1'b0;
        popCheck("accept");
    endtask

    initial begin
        int lastAcc, cyc, n, hold, doneAt, sawDone;

        vecs[0] = '{3'd0, 8'h01}; vecs[1] = '{3'd1, 8'h02};
        vecs[2] = '{3'd2, 8'h04}; vecs[3] = '{3'd3, 8'h08};
        vecs[4] = '{3'd4, 8'h10}; vecs[5] = '{3'd5, 8'h20};
        vecs[6] = '{3'd6, 8'h40}; vecs[7] = '{3'd7, 8'h80};

        rstN = 1'b0; valid = 1'b0; code = 3'd0; pause = 1'b0; clear = 1'b0;
        bRstN = 1'b0; bValid = 1'b0; bCode = 3'd0; bPause = 1'b0; bClear = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check("rstData", data, 8'h00);
        check("rstReady", ready, 1);
        check("rstBusy", busy, 0);
        check("rstDone", done, 0);
        check("rstDataB", bData, 8'hFF);
        check("rstReadyB", bReady, 1);
        rstN = 1'b1;
        bRstN = 1'b1;
        tick();

        // ---- 1: single code 5 ----
        acceptA(3'd5);
        check("t1Ready0", ready, 0);
        check("t1Busy1", busy, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1Hold", data, 8'h20);
        end
        tick();
        check("t1GapData", data, 8'h00);
        check("t1GapBusy", busy, 1);
        check("t1GapDone", done, 0);
        tick();
        check("t1Done", done, 1);
        check("t1DoneReady", ready, 1);
        check("t1DoneBusy", busy, 0);
        tick();
        check("t1DoneOff", done, 0);

        // ---- 2: all codes back-to-back, iValid held ----
        valid = 1'b1;
        code = vecs[0].code;
        expQ.push_back(vecs[0].expData);
        cyc = 0;
        lastAcc = 0;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (ready !== 1'b1 && n < 20) begin
                tick();
                cyc++;
                n++;
                check("t2OneHot", ($countones(data) <= 1) ? 1 : 0, 1);
            end
            check("t2ReadyWait", ready, 1);
            tick();
            cyc++;
            if (i < 7) begin
                code = vecs[i+1].code;
                expQ.push_back(vecs[i+1].expData);
            end else begin
                valid = 1'b0;
            end
            popCheck("walk");
            if (i > 0) check("t2Spacing", cyc - lastAcc, 6);
            lastAcc = cyc;
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t2DoneLatency", n, 5);
        tick();

        // ---- 3: pause mid-HOLD on code 2 ----
        acceptA(3'd2);
        hold = 1;
        doneAt = 0;
        for (int i = 1; i <= 12; i++) begin
            pause = (i >= 2 && i <= 4);
            tick();
            if (data == 8'h04) hold++;
            if (done === 1'b1 && doneAt == 0) doneAt = i;
        end
        pause = 1'b0;
        check("t3HoldLen", hold, 7);
        check("t3DoneAt", doneAt, 8);

        // ---- 4: clear during HOLD, and clear with accept ----
        acceptA(3'd7);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4ClrData", data, 8'h00);
        check("t4ClrReady", ready, 1);
        check("t4ClrBusy", busy, 0);
        check("t4ClrDone", done, 0);
        sawDone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) sawDone++;
        end
        check("t4NoDone", sawDone, 0);
        valid = 1'b1;
        code = 3'd3;
        clear = 1'b1;
        tick();
        valid = 1'b0;
        clear = 1'b0;
        check("t4DropData", data, 8'h00);
        check("t4DropBusy", busy, 0);
        check("t4DropReady", ready, 1);
        tick();
        check("t4DropData2", data, 8'h00);
        $display("[TB] clear tests done");

        // ---- 5: active-low, HOLD=1, GAP=0 on dutB ----
        bValid = 1'b1;
        bCode = 3'd0;
        tick();
        bValid = 1'b0;
        check("t5Strobe", bData, 8'hFE);
        check("t5Busy", bBusy, 1);
        check("t5Ready0", bReady, 0);
        tick();
        check("t5Idle", bData, 8'hFF);
        check("t5Done", bDone, 1);
        check("t5Ready1", bReady, 1);
        check("t5BusyOff", bBusy, 0);
        tick();
        check("t5DoneOff", bDone, 0);
        $display("[TB] dutB code 0 sequence done");

        // ---- 6: asynchronous reset mid-GAP and mid-HOLD ----
        acceptA(3'd1);
        for (int i = 0; i < 4; i++) tick();
        check("t6InGap", busy, 1);
        #2 rstN = 1'b0;
        #1;
        check("t6GapRstReady", ready, 1);
        check("t6GapRstBusy", busy, 0);
        check("t6GapRstData", data, 8'h00);
        check("t6GapRstDone", done, 0);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        acceptA(3'd6);
        tick();
        #2 rstN = 1'b0;
        #1;
        check("t6HoldRstData", data, 8'h00);
        check("t6HoldRstBusy", busy, 0);
        check("t6HoldRstReady", ready, 1);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        $display("[TB] async reset tests done");

        check("sbEmpty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
